// File: rtl/uart_tx_serializer_if.sv
// Handshake, configuration and serial-line signals of the UART transmit stage.
// The master side is the byte source and baud generator; the slave side is the serializer.
interface uart_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic              baudTick_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              parityEn_i;
  logic              parityOdd_i;
  logic              twoStop_i;
  logic              tx_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output baudTick_i, data_i, valid_i, parityEn_i, parityOdd_i, twoStop_i,
    input  ready_o, tx_o, busy_o, done_o
  );

  modport slave (
    input  baudTick_i, data_i, valid_i, parityEn_i, parityOdd_i, twoStop_i,
    output ready_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per valid/ready handshake, framed as start,
// LSB-first data, optional parity and 1 or 2 stop bits, paced by an oversample tick.
module uart_tx_serializer #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic                  clk_i,
  input logic                  arst_ni,
  uart_tx_serializer_if.slave  bus
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
  } state_t;

  state_t            state, state_next;
  logic [TW-1:0]     tick_cnt, tick_cnt_next;
  logic [BW-1:0]     bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0] shift, shift_next;
  logic              parity_bit, parity_bit_next;
  logic              parity_en, parity_en_next;
  logic              two_stop, two_stop_next;
  logic              tx, tx_next;
  logic              done;
  logic              bit_end;

  assign bit_end = bus.baudTick_i && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      parity_en  <= 1'b0;
      two_stop   <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift      <= shift_next;
      parity_bit <= parity_bit_next;
      parity_en  <= parity_en_next;
      two_stop   <= two_stop_next;
      tx         <= tx_next;
    end
  end

  always_comb begin
    state_next      = state;
    tick_cnt_next   = tick_cnt;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift;
    parity_bit_next = parity_bit;
    parity_en_next  = parity_en;
    two_stop_next   = two_stop;
    done            = 1'b0;

    if (state == IDLE) begin
      if (bus.valid_i) begin
        state_next      = START;
        tick_cnt_next   = '0;
        shift_next      = bus.data_i;
        parity_bit_next = (^bus.data_i) ^ bus.parityOdd_i;
        parity_en_next  = bus.parityEn_i;
        two_stop_next   = bus.twoStop_i;
      end
    end else if (bus.baudTick_i) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt + 1'b1;
    end

    case (state)
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            state_next = parity_en ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop) begin
            state_next = STOP2;
          end else begin
            state_next = IDLE;
            done       = 1'b1;
          end
        end
      end
      STOP2: begin
        if (bit_end) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: ;
    endcase

    // Line level is registered from the upcoming state so tx never glitches.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.busy_o  = (state != IDLE);
  assign bus.done_o  = done;
  assign bus.tx_o    = tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a negedge monitor pops expected
// line bits and frame lengths from scoreboard queues filled when frames are accepted.
module tb_uart_tx_serializer;

  localparam int DW  = 8;
  localparam int OVS = 16;

  logic clk_i;
  logic arst_ni;

  uart_tx_serializer_if #(.DATA_W(DW)) bus ();

  uart_tx_serializer #(.DATA_W(DW), .OVERSAMPLE(OVS)) dut (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .bus     (bus)
  );

  int  tests = 0;
  int  fails = 0;
  bit  bitQ[$];
  int  lenQ[$];
  int  tickCount = 0;
  bit  frameActive = 0;
  int  doneCount = 0;
  int  readyErr = 0;
  bit  tickEn = 1;
  int  tickDiv = 0;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  // Baud generator stand-in: one-cycle tick every 4 clocks while enabled.
  initial begin
    bus.baudTick_i = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (tickEn) begin
        if (tickDiv == 3) begin
          bus.baudTick_i = 1;
          tickDiv = 0;
        end else begin
          bus.baudTick_i = 0;
          tickDiv++;
        end
      end else begin
        bus.baudTick_i = 0;
      end
    end
  end

  function automatic void pushFrame(input logic [DW-1:0] d, input bit pen, input bit odd, input bit two);
    bitQ.push_back(1'b0);
    for (int i = 0; i < DW; i++) bitQ.push_back(d[i]);
    if (pen) bitQ.push_back((^d) ^ odd);
    bitQ.push_back(1'b1);
    if (two) bitQ.push_back(1'b1);
    lenQ.push_back(OVS * (1 + DW + int'(pen) + 1 + int'(two)));
  endfunction

  // Monitor: samples each bit mid-way and checks frame length at the done pulse.
  initial begin
    forever begin
      @(negedge clk_i);
      if (frameActive) begin
        if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1) readyErr++;
        if (bus.baudTick_i === 1'b1) begin
          if ((tickCount % OVS) == OVS / 2) begin
            tests++;
            if (bitQ.size() == 0) begin
              fails++;
              $display("[TB] FAIL bit_sample: got tx=%b at tick %0d, required no further bit", bus.tx_o, tickCount);
            end else begin
              bit exp;
              exp = bitQ.pop_front();
              if (bus.tx_o !== exp) begin
                fails++;
                $display("[TB] FAIL bit_sample: got tx=%b at tick %0d, required %b", bus.tx_o, tickCount, exp);
              end
            end
          end
          tickCount++;
        end
        if (bus.done_o === 1'b1) begin
          int expLen;
          expLen = (lenQ.size() > 0) ? lenQ.pop_front() : -1;
          tests++;
          if (tickCount !== expLen) begin
            fails++;
            $display("[TB] FAIL frame_ticks: got %0d ticks accept-to-done, required %0d", tickCount, expLen);
          end
          tests++;
          if (bitQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL frame_bits: got %0d unsent bits at done, required 0", bitQ.size());
          end
          tests++;
          if (readyErr != 0) begin
            fails++;
            $display("[TB] FAIL ready_busy: got %0d cycles with ready/busy wrong mid-frame, required 0", readyErr);
          end
          doneCount++;
          frameActive = 0;
        end
      end else begin
        if (bus.done_o === 1'b1) begin
          tests++;
          fails++;
          doneCount++;
          $display("[TB] FAIL stray_done: got done_o=1 outside a frame, required 0");
        end
        if (arst_ni && bus.valid_i && bus.ready_o) begin
          frameActive = 1;
          tickCount = 0;
          readyErr = 0;
        end
      end
    end
  end

  task automatic sendFrame(input logic [DW-1:0] d, input bit pen, input bit odd, input bit two);
    bit accepted = 0;
    @(posedge clk_i);
    #1;
    bus.data_i      = d;
    bus.parityEn_i  = pen;
    bus.parityOdd_i = odd;
    bus.twoStop_i   = two;
    bus.valid_i     = 1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_i);
      if (bus.ready_o === 1'b1) begin
        pushFrame(d, pen, odd, two);
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got ready_o=%b after 5000 cycles, required 1", bus.ready_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic waitDone(input int target, input string name);
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk_i);
      if (doneCount >= target) break;
    end
    #1;
    tests++;
    if (doneCount < target) begin
      fails++;
      $display("[TB] FAIL %s_done_timeout: got %0d done pulses, required %0d", name, doneCount, target);
    end
  endtask

  task automatic test_reset();
    arst_ni = 0;
    #12;
    tests += 4;
    if (bus.tx_o !== 1'b1)    begin fails++; $display("[TB] FAIL reset_tx: got %b, required 1", bus.tx_o); end
    if (bus.ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b, required 1", bus.ready_o); end
    if (bus.busy_o !== 1'b0)  begin fails++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy_o); end
    if (bus.done_o !== 1'b0)  begin fails++; $display("[TB] FAIL reset_done: got %b, required 0", bus.done_o); end
    @(posedge clk_i);
    #2;
    arst_ni = 1;
  endtask

  task automatic test_8n1();
    int target;
    target = doneCount + 1;
    sendFrame(8'h55, 0, 0, 0);
    bus.valid_i = 0;
    waitDone(target, "8n1");
    repeat (40) @(posedge clk_i);
    tests++;
    if (doneCount !== target) begin
      fails++;
      $display("[TB] FAIL 8n1_single_done: got %0d done pulses, required %0d", doneCount, target);
    end
  endtask

  task automatic test_parity();
    int target;
    target = doneCount + 1;
    sendFrame(8'h00, 1, 0, 0);
    bus.valid_i = 0;
    waitDone(target, "parity_even");
    target = doneCount + 1;
    sendFrame(8'h00, 1, 1, 0);
    bus.valid_i = 0;
    waitDone(target, "parity_odd");
  endtask

  task automatic test_two_stop();
    int target;
    target = doneCount + 1;
    sendFrame(8'hA3, 1, 0, 1);
    bus.valid_i = 0;
    waitDone(target, "two_stop");
  endtask

  task automatic test_back_to_back();
    int target;
    target = doneCount + 2;
    sendFrame(8'h12, 0, 0, 0);
    sendFrame(8'h34, 0, 0, 0);
    bus.valid_i = 0;
    waitDone(target, "back_to_back");
  endtask

  task automatic test_reset_abort();
    int doneBefore;
    int target;
    bit reached = 0;
    sendFrame(8'hF0, 0, 0, 0);
    bus.valid_i = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk_i);
      #2;
      if (tickCount >= 4 * OVS + 6) begin reached = 1; break; end
    end
    tests++;
    if (!reached || bus.tx_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_pre_tx: got tx=%b reached=%0d in data bit 3, required tx=0", bus.tx_o, reached);
    end
    doneBefore = doneCount;
    arst_ni = 0;
    frameActive = 0;
    bitQ.delete();
    lenQ.delete();
    #1;
    tests += 2;
    if (bus.tx_o !== 1'b1)    begin fails++; $display("[TB] FAIL abort_tx: got %b, required 1", bus.tx_o); end
    if (bus.ready_o !== 1'b1) begin fails++; $display("[TB] FAIL abort_ready: got %b, required 1", bus.ready_o); end
    repeat (3) @(posedge clk_i);
    #2;
    arst_ni = 1;
    repeat (20) @(posedge clk_i);
    tests++;
    if (doneCount !== doneBefore) begin
      fails++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses, required %0d", doneCount, doneBefore);
    end
    target = doneCount + 1;
    sendFrame(8'h0F, 0, 0, 0);
    bus.valid_i = 0;
    waitDone(target, "after_abort");
  endtask

  task automatic test_pause();
    int target;
    int heldCount;
    int changes = 0;
    logic held;
    target = doneCount + 1;
    sendFrame(8'h55, 0, 0, 0);
    bus.valid_i = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk_i);
      #2;
      if (tickCount >= 37) break;
    end
    tickEn = 0;
    repeat (2) @(posedge clk_i);
    #2;
    held = bus.tx_o;
    heldCount = tickCount;
    repeat (50) begin
      @(posedge clk_i);
      #2;
      if (bus.tx_o !== held) changes++;
    end
    tests += 2;
    if (changes != 0) begin
      fails++;
      $display("[TB] FAIL pause_hold: got %0d tx changes while ticks stopped, required 0", changes);
    end
    if (tickCount != heldCount || bus.busy_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pause_state: got ticks %0d busy=%b, required %0d busy=1", tickCount, bus.busy_o, heldCount);
    end
    tickEn = 1;
    waitDone(target, "pause");
  endtask

  initial begin
    bus.data_i      = '0;
    bus.valid_i     = 0;
    bus.parityEn_i  = 0;
    bus.parityOdd_i = 0;
    bus.twoStop_i   = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_abort();
    test_pause();
    repeat (10) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
